// File: rtl/fofb_dma_sched.sv
// fofb_dma_sched
// Per-timeframe DMA scheduler in front of the TX engine's memory-write path.
// Each rising edge of timeframe_end_i starts a frame: tlp_count_i memory-write
// TLPs of tlp_len_i DWORDs are requested one at a time into a circular host
// buffer. The scheduler also counts frames and raises an interrupt every
// irq_every_i frames.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   enable_i            scheduler enable
//   timeframe_end_i     frame marker level; rising edge starts a frame
//   buf_base_i          host buffer base byte address (DWORD aligned)
//   buf_size_i          host buffer size in bytes
//   tlp_len_i           DWORDs per TLP, 0 means 1024
//   tlp_count_i         TLPs per frame
//   irq_every_i         frames per interrupt, 0 disables interrupts
//   mwr_start_o         one-cycle request pulse to the TX engine
//   mwr_addr_o          TLP host address, held until mwr_done_i
//   mwr_len_o           TLP length, held until mwr_done_i
//   mwr_done_i          TX engine has sent the TLP
//   irq_o               one-cycle interrupt pulse
//   busy_o              high outside IDLE
//   overrun_o           sticky: a frame start arrived while busy
//   frame_cnt_o         completed-frame counter
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a frame start; offset cleared while disabled
// CHECK     | frame done? disabled? otherwise apply wrap rule
// ISSUE     | request pulse on mwr_start_o is out this cycle
// WAIT      | waiting for mwr_done_i from the TX engine
// FRAME_END | count the frame, interrupt divider

module fofb_dma_sched #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              timeframe_end_i,
  input  logic [ADDR_W-1:0] buf_base_i,
  input  logic [ADDR_W-1:0] buf_size_i,
  input  logic [9:0]        tlp_len_i,
  input  logic [CNT_W-1:0]  tlp_count_i,
  input  logic [7:0]        irq_every_i,
  output logic              mwr_start_o,
  output logic [ADDR_W-1:0] mwr_addr_o,
  output logic [9:0]        mwr_len_o,
  input  logic              mwr_done_i,
  output logic              irq_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic [31:0]       frame_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_FRAME_END
  } state_t;

  state_t            state;
  logic              te_q;
  logic              rise;
  logic [ADDR_W-1:0] offset;
  logic [9:0]        len_r;
  logic [CNT_W-1:0]  left;
  logic [7:0]        irq_every_r;
  logic [7:0]        irq_cnt;
  logic [12:0]       bytes;
  logic [ADDR_W:0]   end_ext;
  logic [ADDR_W-1:0] issue_off;

  assign rise  = timeframe_end_i & ~te_q;
  assign bytes = (len_r == 10'd0) ? 13'd4096 : {1'b0, len_r, 2'b00};

  // One extra bit so offset + bytes cannot wrap before the size compare.
  assign end_ext   = {1'b0, offset} + {{(ADDR_W-12){1'b0}}, bytes};
  assign issue_off = (end_ext > {1'b0, buf_size_i}) ? '0 : offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      te_q        <= 1'b0;
      offset      <= '0;
      len_r       <= '0;
      left        <= '0;
      irq_every_r <= '0;
      irq_cnt     <= '0;
      mwr_start_o <= 1'b0;
      mwr_addr_o  <= '0;
      mwr_len_o   <= '0;
      irq_o       <= 1'b0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      te_q        <= timeframe_end_i;
      mwr_start_o <= 1'b0;
      irq_o       <= 1'b0;

      // Frame starts while busy are dropped, only flagged.
      if (rise && state != S_IDLE)
        overrun_o <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!enable_i) begin
            offset    <= '0;
            overrun_o <= 1'b0;
          end else if (rise) begin
            len_r       <= tlp_len_i;
            left        <= tlp_count_i;
            irq_every_r <= irq_every_i;
            busy_o      <= 1'b1;
            state       <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (left == '0) begin
            state <= S_FRAME_END;
          end else if (!enable_i) begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else begin
            offset      <= issue_off;
            mwr_addr_o  <= buf_base_i + issue_off;
            mwr_len_o   <= len_r;
            mwr_start_o <= 1'b1;
            state       <= S_ISSUE;
          end
        end

        S_ISSUE: state <= S_WAIT;

        S_WAIT: begin
          if (mwr_done_i) begin
            offset <= offset + {{(ADDR_W-13){1'b0}}, bytes};
            left   <= left - {{(CNT_W-1){1'b0}}, 1'b1};
            state  <= S_CHECK;
          end
        end

        S_FRAME_END: begin
          frame_cnt_o <= frame_cnt_o + 32'd1;
          if (irq_every_r != 8'd0) begin
            if (irq_cnt + 8'd1 == irq_every_r) begin
              irq_o   <= 1'b1;
              irq_cnt <= 8'd0;
            end else begin
              irq_cnt <= irq_cnt + 8'd1;
            end
          end
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fofb_dma_sched.sv
// Testbench for fofb_dma_sched: directed scenarios plus randomized frames,
// checked against a transaction-level model of the scheduler.
module tb_fofb_dma_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic        timeframe_end_i;
  logic [31:0] buf_base_i;
  logic [31:0] buf_size_i;
  logic [9:0]  tlp_len_i;
  logic [15:0] tlp_count_i;
  logic [7:0]  irq_every_i;
  logic        mwr_start_o;
  logic [31:0] mwr_addr_o;
  logic [9:0]  mwr_len_o;
  logic        mwr_done_i;
  logic        irq_o;
  logic        busy_o;
  logic        overrun_o;
  logic [31:0] frame_cnt_o;

  fofb_dma_sched dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .timeframe_end_i(timeframe_end_i),
    .buf_base_i     (buf_base_i),
    .buf_size_i     (buf_size_i),
    .tlp_len_i      (tlp_len_i),
    .tlp_count_i    (tlp_count_i),
    .irq_every_i    (irq_every_i),
    .mwr_start_o    (mwr_start_o),
    .mwr_addr_o     (mwr_addr_o),
    .mwr_len_o      (mwr_len_o),
    .mwr_done_i     (mwr_done_i),
    .irq_o          (irq_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [9:0]  l;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  bit          lat_pending = 0;
  int          frame_starts = 0;
  logic [31:0] first_addr = '0;
  logic [31:0] last_addr = '0;
  int          irq_seen = 0;
  bit          resp_rand = 0;

  // model state
  longint      mo = 0;
  int          exp_frames = 0;
  int          exp_irq = 0;
  int          ic = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Model: what one frame must produce, from the buffer rules alone.
  task automatic model_frame(input int n, input bit counted);
    longint bytes;
    exp_t   e;
    bytes = (tlp_len_i == 10'd0) ? 64'd4096 : longint'(tlp_len_i) * 4;
    for (int k = 0; k < n; k++) begin
      if (mo + bytes > longint'(buf_size_i)) mo = 0;
      e.a = buf_base_i + 32'(mo);
      e.l = tlp_len_i;
      q.push_back(e);
      mo += bytes;
    end
    if (counted) begin
      exp_frames++;
      if (irq_every_i != 8'd0) begin
        ic++;
        if (ic == int'(irq_every_i)) begin
          exp_irq++;
          ic = 0;
        end
      end
    end
  endtask

  // Compare process: every request pulse against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mwr_start_o) begin
        if (frame_starts == 0) first_addr = mwr_addr_o;
        frame_starts++;
        last_addr = mwr_addr_o;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start actual addr=0x%0h expected=no request", mwr_addr_o);
        end else begin
          e = q.pop_front();
          chk("mwr_addr", {32'd0, mwr_addr_o}, {32'd0, e.a});
          chk("mwr_len", {54'd0, mwr_len_o}, {54'd0, e.l});
        end
        if (lat_pending) begin
          chk("start_latency", 64'(cyc - rise_cyc), 64'd2);
          lat_pending = 0;
        end
      end
      if (irq_o) irq_seen++;
    end
  end

  // TX engine stand-in: done pulse a few cycles after each request.
  initial begin
    mwr_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (mwr_start_o) begin
        repeat (resp_rand ? $urandom_range(1, 5) : 3) @(posedge clk);
        #1 mwr_done_i = 1'b1;
        @(posedge clk);
        #1 mwr_done_i = 1'b0;
      end
    end
  end

  task automatic start_frame(input int n);
    @(posedge clk);
    #1 timeframe_end_i = 1'b1;
    rise_cyc = cyc;
    lat_pending = (n > 0);
    frame_starts = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy_o) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual busy=1 expected busy=0");
    end
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 timeframe_end_i = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    bit done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (frame_starts >= n) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL start_timeout actual=%0d expected=%0d", frame_starts, n);
    end
  endtask

  task automatic frame_checks(input string nm);
    chk({nm, "_frame_cnt"}, {32'd0, frame_cnt_o}, 64'(exp_frames));
    chk({nm, "_irq_count"}, 64'(irq_seen), 64'(exp_irq));
    chk({nm, "_pending"}, 64'(q.size()), 64'd0);
  endtask

  task automatic run_frame(input string nm);
    model_frame(int'(tlp_count_i), 1);
    start_frame(int'(tlp_count_i));
    wait_idle();
    frame_checks(nm);
  endtask

  task automatic set_disable();
    @(posedge clk);
    #1 enable_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mo = 0;
    chk("overrun_cleared", {63'd0, overrun_o}, 64'd0);
    @(posedge clk);
    #1 enable_i = 1'b1;
  endtask

  initial begin
    int irq0;
    rst = 1'b1;
    enable_i = 1'b0;
    timeframe_end_i = 1'b0;
    buf_base_i = 32'h1000_0000;
    buf_size_i = 32'h0001_0000;
    tlp_len_i = 10'd32;
    tlp_count_i = 16'd16;
    irq_every_i = 8'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", {63'd0, mwr_start_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_frame_cnt", {32'd0, frame_cnt_o}, 64'd0);
    chk("rst_overrun_irq", {62'd0, overrun_o, irq_o}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    enable_i = 1'b1;

    // basic burst, rise at cycle 996
    while (cyc < 995) @(posedge clk);
    run_frame("basic");
    chk("basic_frame_cnt_lit", {32'd0, frame_cnt_o}, 64'd1);
    chk("basic_irq_lit", 64'(irq_seen), 64'd1);
    chk("basic_first_addr", {32'd0, first_addr}, 64'h1000_0000);
    chk("basic_last_addr", {32'd0, last_addr}, 64'h1000_0780);
    chk("basic_starts", 64'(frame_starts), 64'd16);

    // wrap
    set_disable();
    buf_size_i = 32'h200;
    tlp_count_i = 16'd6;
    run_frame("wrap1");
    chk("wrap1_last_addr", {32'd0, last_addr}, 64'h1000_0080);
    run_frame("wrap2");
    chk("wrap2_first_addr", {32'd0, first_addr}, 64'h1000_0100);

    // overrun
    buf_size_i = 32'h0001_0000;
    tlp_count_i = 16'd16;
    chk("overrun_pre", {63'd0, overrun_o}, 64'd0);
    model_frame(16, 1);
    start_frame(16);
    wait_starts(4);
    @(posedge clk);
    #1 timeframe_end_i = 1'b0;
    @(posedge clk);
    #1 timeframe_end_i = 1'b1;
    wait_idle();
    frame_checks("overrun");
    chk("overrun_set", {63'd0, overrun_o}, 64'd1);
    chk("overrun_starts", 64'(frame_starts), 64'd16);
    set_disable();

    // disable after third start
    buf_base_i = 32'h2000_0000;
    tlp_count_i = 16'd8;
    model_frame(3, 0);
    start_frame(8);
    wait_starts(3);
    @(posedge clk);
    #1 enable_i = 1'b0;
    wait_idle();
    mo = 0;
    frame_checks("disable");
    chk("disable_starts", 64'(frame_starts), 64'd3);
    @(posedge clk);
    #1 enable_i = 1'b1;
    tlp_count_i = 16'd2;
    run_frame("after_disable");
    chk("after_disable_first", {32'd0, first_addr}, 64'h2000_0000);

    // reset during WAIT
    tlp_count_i = 16'd8;
    model_frame(2, 0);
    start_frame(8);
    wait_starts(2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs",
        {mwr_addr_o, 12'd0, mwr_len_o, mwr_start_o, irq_o, busy_o, overrun_o},
        64'd0);
    chk("midrst_frame_cnt", {32'd0, frame_cnt_o}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    timeframe_end_i = 1'b0;
    lat_pending = 0;
    mo = 0;
    ic = 0;
    exp_frames = 0;
    repeat (12) @(posedge clk);
    chk("midrst_pending", 64'(q.size()), 64'd0);
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);

    // irq divider
    irq_every_i = 8'd4;
    tlp_count_i = 16'd1;
    irq0 = irq_seen;
    for (int f = 0; f < 10; f++) run_frame("irq4");
    chk("irq4_pulses", 64'(irq_seen - irq0), 64'd2);
    irq_every_i = 8'd0;
    irq0 = irq_seen;
    for (int f = 0; f < 3; f++) run_frame("irq0");
    chk("irq0_pulses", 64'(irq_seen - irq0), 64'd0);

    // corner lengths
    tlp_count_i = 16'd0;
    run_frame("count0");
    chk("count0_starts", 64'(frame_starts), 64'd0);
    set_disable();
    buf_size_i = 32'h0010_0000;
    tlp_len_i = 10'd0;
    tlp_count_i = 16'd3;
    run_frame("len0");
    chk("len0_last_addr", {32'd0, last_addr}, 64'h2000_2000);

    // randomized frames; working config scrambled right after each start
    resp_rand = 1;
    for (int f = 0; f < 20; f++) begin
      int n;
      if ($urandom_range(0, 3) == 0) set_disable();
      buf_base_i  = $urandom & 32'hFFFF_FFFC;
      buf_size_i  = ($urandom_range(0, 1) != 0) ? ($urandom_range(0, 32'h3000) & 32'hFFFF_FFFC)
                                                : 32'($urandom_range(0, 64));
      tlp_len_i   = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
      tlp_count_i = 16'($urandom_range(0, 6));
      irq_every_i = 8'($urandom_range(0, 3));
      n = int'(tlp_count_i);
      model_frame(n, 1);
      start_frame(n);
      @(posedge clk);
      #1 tlp_len_i = 10'($urandom);
      tlp_count_i = 16'($urandom_range(0, 20));
      irq_every_i = 8'($urandom);
      wait_idle();
      frame_checks("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fofb_dma_sched.md
Name: fofb_dma_sched

Overview:
- Per-timeframe DMA scheduler that sequences the BMD TX engine's memory-write path.
- On each rising edge of timeframe_end_i it issues a burst of tlp_count_i memory-write TLPs of tlp_len_i DWORDs into a circular host buffer. It advances and wraps the host address, counts frames and raises a DMA interrupt every irq_every_i frames.
- Sits between the CC timeframe logic / BAR registers and the TX engine's mwr_* request interface.

Parameters:
- ADDR_W, 32, host buffer address and size width (bytes).
- CNT_W, 16, width of the TLP-per-frame count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable_i  in  1  scheduler enable (BAR control bit)
- timeframe_end_i  in  1  level from CC; its rising edge starts a frame
- buf_base_i  in  ADDR_W  host buffer base byte address, DWORD aligned
- buf_size_i  in  ADDR_W  host buffer size in bytes
- tlp_len_i  in  10  payload DWORDs per TLP; 0 encodes 1024
- tlp_count_i  in  CNT_W  TLPs per frame
- irq_every_i  in  8  frames per interrupt; 0 disables interrupts
- mwr_start_o  out  1  one-cycle request pulse to the TX engine
- mwr_addr_o  out  ADDR_W  TLP host address, valid with mwr_start_o and held until mwr_done_i
- mwr_len_o  out  10  TLP length, same timing as mwr_addr_o
- mwr_done_i  in  1  one-cycle pulse when the TX engine has sent the TLP
- irq_o  out  1  one-cycle interrupt pulse (drives wdma_irq)
- busy_o  out  1  high outside IDLE
- overrun_o  out  1  sticky; set when a frame start is missed
- frame_cnt_o  out  32  completed-frame counter

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, state IDLE, offset 0, irq counter 0, te_q 0.
- Edge detect: te_q <= timeframe_end_i; rise = timeframe_end_i & ~te_q. A level held high gives exactly one rise.
- FSM states: IDLE, CHECK, ISSUE, WAIT, FRAME_END.
- IDLE:
  - enable_i=0: offset cleared to 0.
  - enable_i=1 and rise: latch tlp_len/tlp_count/irq_every into working registers, left <= tlp_count, go CHECK.
- CHECK:
  - left=0 -> FRAME_END.
  - enable_i=0 -> IDLE; frame not counted.
  - Wrap rule: bytes = len*4 (4096 when len=0). If offset + bytes > buf_size_i, offset <= 0.
  - Then -> ISSUE.
- ISSUE:
  - Drive mwr_start_o=1 for exactly one cycle, mwr_addr_o = buf_base_i + offset, mwr_len_o = len.
  - Go WAIT.
  - Latency from rise to first mwr_start_o: 2 cycles (rise cycle -> CHECK -> ISSUE).
- WAIT:
  - On mwr_done_i: offset += bytes, left -= 1, go CHECK.
  - mwr_done_i in any other state is ignored.
  - No timeout.
- FRAME_END (1 cycle):
  - frame_cnt_o += 1, wrapping at 2^32.
  - If irq_every != 0: irq_cnt += 1. When irq_cnt+1 == irq_every, irq_o=1 for this cycle and irq_cnt <= 0.
  - Go IDLE.
- Overrun:
  - A rise seen while not in IDLE sets overrun_o. The frame is dropped, not queued.
  - overrun_o clears only on rst or in IDLE with enable_i=0.
- A rise coincident with the FRAME_END cycle counts as overrun.
- Reset mid-burst: immediate return to IDLE, no further mwr_start_o. A pending mwr_done_i is ignored.
- Config inputs change only take effect at the next frame start (latched). buf_base_i and buf_size_i are sampled live in CHECK/ISSUE.
- buf_size_i < bytes: offset stays 0 and every TLP targets buf_base_i.

Test Plan:
- Basic burst:
  - Stimulus: base=0x1000_0000, size=0x10000, len=32, count=16, irq_every=1; rise at cycle 996; TX returns mwr_done 3 cycles after each start.
  - Required: 16 starts at addresses 0x1000_0000 + k*0x80, first start 2 cycles after the rise; then frame_cnt=1 and one irq_o pulse.
- Wrap:
  - Stimulus: size=0x200, len=32, count=6.
  - Required: addresses base + 0x0, 0x80, 0x100, 0x180, 0x0, 0x80.
  - Second frame continues from offset 0x100.
- Overrun:
  - Stimulus: toggle timeframe_end_i low then high again during a 16-TLP burst.
  - Required: overrun_o=1, still exactly 16 starts, frame_cnt increments once.
  - Stimulus: enable_i=0 in IDLE.
  - Required: overrun_o clears.
- IRQ divide:
  - Stimulus: irq_every=4, 10 frames with count=1.
  - Required: irq_o after frames 4 and 8 only.
  - Stimulus: irq_every=0.
  - Required: no irq_o.
- Corner lengths:
  - Stimulus: count=0.
  - Required: no starts, frame_cnt increments.
  - Stimulus: len=0.
  - Required: mwr_len_o=0 and address step 4096.
- Disable and reset mid-burst:
  - Stimulus: enable_i=0 after the 3rd start.
  - Required: that TLP completes, no 4th start, frame_cnt unchanged, offset 0.
  - Stimulus: rst during WAIT.
  - Required: all outputs 0 the next cycle.
